// File: rtl/frame_capture_ctrl.sv
// Frame capture controller: locks onto a byte stream framed by a periodic header,
// then forwards a requested number of frames downstream with loss/overflow/timeout detection.
module frame_capture_ctrl #(
  parameter int unsigned FRAME_WIDTH  = 48,
  parameter logic [7:0]  HEADER       = 8'hBC,
  parameter int unsigned LOCK_HEADERS = 2,
  parameter int unsigned TIMEOUT      = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_start,
  input  logic        cmd_abort,
  input  logic [15:0] nframes,
  input  logic [7:0]  fd,
  input  logic        fifo_full,
  output logic [7:0]  cap_data,
  output logic        cap_en,
  output logic        busy,
  output logic        done,
  output logic [15:0] frame_cnt,
  output logic        err_lost,
  output logic        err_ovf,
  output logic        err_timeout,
  output logic [2:0]  state
);

  localparam int unsigned PW = $clog2(FRAME_WIDTH);
  localparam int unsigned LW = $clog2(LOCK_HEADERS + 1);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam logic [PW-1:0] POS_LAST = PW'(FRAME_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SEARCH  = 3'd1,
    LOCK    = 3'd2,
    CAPTURE = 3'd3,
    DONE    = 3'd4,
    ERROR   = 3'd5
  } state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] pos_q, pos_d, pos_nxt;
  logic [LW-1:0] lock_q, lock_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [15:0]   nfr_q, nfr_d;
  logic [15:0]   fcnt_q, fcnt_d;
  logic [7:0]    cap_data_q;
  logic          cap_en_q, cap_en_d;
  logic          busy_q, done_q;
  logic          lost_q, lost_d;
  logic          ovf_q, ovf_d;
  logic          tmo_err_q, tmo_err_d;
  logic          hdr_ok, tmo_hit;

  assign pos_nxt = (pos_q == POS_LAST) ? '0 : pos_q + 1'b1;
  assign hdr_ok  = (fd == HEADER);
  assign tmo_hit = (tmo_q == TW'(TIMEOUT - 1));

  always_comb begin
    state_d   = state_q;
    pos_d     = pos_q;
    lock_d    = lock_q;
    tmo_d     = tmo_q;
    nfr_d     = nfr_q;
    fcnt_d    = fcnt_q;
    cap_en_d  = 1'b0;
    lost_d    = lost_q;
    ovf_d     = ovf_q;
    tmo_err_d = tmo_err_q;

    if (cmd_abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE, ERROR: begin
          if (cmd_start) begin
            nfr_d     = nframes;
            fcnt_d    = '0;
            pos_d     = '0;
            lock_d    = '0;
            tmo_d     = '0;
            lost_d    = 1'b0;
            ovf_d     = 1'b0;
            tmo_err_d = 1'b0;
            state_d   = (nframes == '0) ? DONE : SEARCH;
          end
        end
        SEARCH: begin
          tmo_d = tmo_q + 1'b1;
          if (tmo_hit) begin
            state_d   = ERROR;
            tmo_err_d = 1'b1;
          end else if (hdr_ok) begin
            pos_d  = PW'(1);
            lock_d = LW'(1);
            if (LOCK_HEADERS == 1) begin
              state_d  = CAPTURE;
              cap_en_d = 1'b1;
            end else begin
              state_d = LOCK;
            end
          end
        end
        LOCK: begin
          tmo_d = tmo_q + 1'b1;
          pos_d = pos_nxt;
          if (tmo_hit) begin
            state_d   = ERROR;
            tmo_err_d = 1'b1;
          end else if (pos_q == '0) begin
            if (!hdr_ok) begin
              state_d = SEARCH;
              lock_d  = '0;
            end else if (lock_q + 1'b1 == LW'(LOCK_HEADERS)) begin
              state_d  = CAPTURE;
              cap_en_d = 1'b1;
            end else begin
              lock_d = lock_q + 1'b1;
            end
          end
        end
        CAPTURE: begin
          pos_d = pos_nxt;
          // Overflow is checked first so a full FIFO masks a simultaneous lost header.
          if (fifo_full) begin
            state_d = ERROR;
            ovf_d   = 1'b1;
          end else if (pos_q == '0 && !hdr_ok) begin
            state_d = ERROR;
            lost_d  = 1'b1;
          end else begin
            cap_en_d = 1'b1;
            if (pos_q == POS_LAST) begin
              fcnt_d = fcnt_q + 16'd1;
              if (fcnt_q + 16'd1 == nfr_q) state_d = DONE;
            end
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      pos_q      <= '0;
      lock_q     <= '0;
      tmo_q      <= '0;
      nfr_q      <= '0;
      fcnt_q     <= '0;
      cap_data_q <= '0;
      cap_en_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      lost_q     <= 1'b0;
      ovf_q      <= 1'b0;
      tmo_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pos_q      <= pos_d;
      lock_q     <= lock_d;
      tmo_q      <= tmo_d;
      nfr_q      <= nfr_d;
      fcnt_q     <= fcnt_d;
      cap_data_q <= fd;
      cap_en_q   <= cap_en_d;
      busy_q     <= (state_d == SEARCH) || (state_d == LOCK) || (state_d == CAPTURE);
      done_q     <= (state_d == DONE);
      lost_q     <= lost_d;
      ovf_q      <= ovf_d;
      tmo_err_q  <= tmo_err_d;
    end
  end

  assign state       = state_q;
  assign cap_data    = cap_data_q;
  assign cap_en      = cap_en_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign frame_cnt   = fcnt_q;
  assign err_lost    = lost_q;
  assign err_ovf     = ovf_q;
  assign err_timeout = tmo_err_q;

endmodule

// File: doc/frame_capture_ctrl.md
FRAME_CAPTURE_CTRL -- requirements
Module: frame_capture_ctrl

Interface
REQ-001 SHALL have parameter FRAME_WIDTH, default 48, bytes per frame including header.
REQ-002 SHALL have parameter HEADER, default 8'hBC, K28.5 header byte value.
REQ-003 SHALL have parameter LOCK_HEADERS, default 2, consecutive correctly spaced headers needed for lock.
REQ-004 SHALL have parameter TIMEOUT, default 4096, max cycles in SEARCH+LOCK.
REQ-005 SHALL have ports: clk in 1, rising-edge clock; rst in 1, reset, asynchronous, active-high.
REQ-006 SHALL have ports: cmd_start in 1, run request pulse; cmd_abort in 1, abort pulse; nframes in 16, frames to capture.
REQ-007 SHALL have ports: fd in 8, parallel byte, one per cycle, fd[7] = first serial bit; fifo_full in 1, downstream full.
REQ-008 SHALL have ports: cap_data out 8, registered fd; cap_en out 1, cap_data valid for packer/FIFO.
REQ-009 SHALL have ports: busy out 1; done out 1, pulse; frame_cnt out 16; err_lost out 1; err_ovf out 1; err_timeout out 1; state out 3.

Function
REQ-010 SHALL register all outputs on posedge clk; cap_data = fd of previous cycle, always.
REQ-011 SHALL implement states IDLE=0, SEARCH=1, LOCK=2, CAPTURE=3, DONE=4, ERROR=5, reported on state.
REQ-012 IDLE: cmd_start=1 at edge N -> latch nframes, clear frame_cnt/errors, SEARCH from N+1; if nframes=0 -> DONE instead.
REQ-013 SEARCH: fd==HEADER -> pos<=1, lock_cnt<=1, LOCK (LOCK_HEADERS=1 -> CAPTURE directly, header forwarded).
REQ-014 LOCK: pos increments each cycle, wraps FRAME_WIDTH-1 -> 0; at pos=0 fd must equal HEADER.
REQ-015 LOCK, pos=0, fd==HEADER: lock_cnt+1; on reaching LOCK_HEADERS -> CAPTURE, that header forwarded (cap_en=1 next cycle).
REQ-016 LOCK, pos=0, fd!=HEADER: -> SEARCH, lock_cnt cleared; no error flagged.
REQ-017 SHALL count timeout cycles from SEARCH entry; reaching TIMEOUT in SEARCH/LOCK -> ERROR, err_timeout=1.
REQ-018 CAPTURE: each byte forwarded, cap_en=1 one cycle after its fd cycle; pos tracked as in LOCK.
REQ-019 CAPTURE, pos=0, fd!=HEADER: -> ERROR, err_lost=1, byte not forwarded.
REQ-020 CAPTURE, fifo_full=1 at any edge: -> ERROR, err_ovf=1, that byte not forwarded; fifo_full takes priority over REQ-019.
REQ-021 CAPTURE, pos=FRAME_WIDTH-1: frame_cnt+1; if new value == latched nframes -> DONE (last byte still forwarded).
REQ-022 DONE: done=1 for exactly one cycle, then IDLE; cap_en=0 in DONE.
REQ-023 ERROR: hold error flags, cap_en=0; cmd_start -> same as REQ-012; cmd_abort -> IDLE, flags kept.
REQ-024 cmd_abort in any state -> IDLE next edge, cap_en=0 next cycle; abort wins over cmd_start same edge.
REQ-025 cmd_start outside IDLE/ERROR SHALL be ignored.
REQ-026 busy=1 in SEARCH, LOCK, CAPTURE; 0 otherwise.
REQ-027 frame_cnt 16-bit, never wraps within run (nframes<=65535), held after DONE until next start.
REQ-028 Header bytes occurring at pos!=0 SHALL be treated as data (no resync in CAPTURE).

Reset
REQ-029 rst=1 SHALL asynchronously force IDLE; cap_en, busy, done, errors = 0; cap_data, frame_cnt, pos, counters = 0.
REQ-030 Release of rst SHALL take effect on first posedge with rst=0; rst mid-capture discards the run without done.

Verification
REQ-031 Defaults, nframes=3, headers every 48 bytes from cycle 10, start at 2 -> lock at 2nd header, 144 cap_en cycles, frame_cnt=3, one done pulse.
REQ-032 Header spacing 47 once during LOCK -> back to SEARCH, no error, lock on next two correct headers.
REQ-033 Mid CAPTURE, byte at pos=0 = 8'h3C -> err_lost=1, state=5, cap_en=0 from that byte.
REQ-034 fifo_full=1 during frame 2 -> err_ovf=1, frame_cnt=1; same cycle bad header -> only err_ovf.
REQ-035 No header on fd for 4096 cycles after start -> err_timeout=1, state=5; then cmd_start -> flags cleared, SEARCH.
REQ-036 nframes=0 start -> done next cycle, cap_en never 1; abort during CAPTURE -> IDLE, no done; rst mid-capture -> all outputs 0.
